// File: rtl/fifo_word_packer.sv
// Pops entries from an upstream FIFO and packs LANES of them into one output word,
// oldest entry in lane 0; a flush emits a partial word with out_keep marking valid lanes.
module fifo_word_packer #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fifo_empty,
  output logic                     fifo_rd_en,
  input  logic [WIDTH-1:0]         fifo_data,
  input  logic                     flush,
  output logic [WIDTH*LANES-1:0]   out_data,
  output logic [LANES-1:0]         out_keep,
  output logic                     out_valid,
  input  logic                     out_ready
);

  localparam int              CW   = $clog2(LANES + 1);
  localparam logic [CW-1:0]   LAST = CW'(LANES - 1);
  localparam logic [CW:0]     FULL = (CW + 1)'(LANES);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t                       state, state_nxt;
  logic [CW-1:0]                cnt;
  logic                         pend;
  logic                         flush_req;
  logic [LANES-1:0][WIDTH-1:0]  lanes;
  logic [LANES-1:0]             keep;
  logic [CW:0]                  occ;
  logic                         capture_last;
  logic                         flush_go;
  logic                         flush_emit;

  function automatic logic [LANES-1:0] keep_mask(input logic [CW-1:0] n);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) m[i] = (CW'(i) < n);
    return m;
  endfunction

  // Lanes already captured plus the one still in flight bound the pop rate.
  assign occ = {1'b0, cnt} + {{CW{1'b0}}, pend};

  always_comb begin
    state_nxt    = state;
    capture_last = pend && (cnt == LAST);
    flush_go     = (state == FILL) && flush_req && !pend;
    flush_emit   = flush_go && (cnt != '0);
    fifo_rd_en   = !rst && (state == FILL) && !fifo_empty && (occ < FULL) && !flush_req;
    out_valid    = !rst && (state == DRAIN);
    case (state)
      FILL:    if (capture_last || flush_emit) state_nxt = DRAIN;
      DRAIN:   if (out_ready) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      pend      <= 1'b0;
      flush_req <= 1'b0;
      lanes     <= '0;
      keep      <= '0;
    end else begin
      pend <= fifo_rd_en;
      // A new pulse wins over clearing so a back-to-back flush is never lost.
      if (flush)         flush_req <= 1'b1;
      else if (flush_go) flush_req <= 1'b0;

      if (state == DRAIN) begin
        if (out_ready) begin
          cnt   <= '0;
          lanes <= '0;
          keep  <= '0;
        end
      end else if (pend) begin
        for (int i = 0; i < LANES; i++)
          if (cnt == CW'(i)) lanes[i] <= fifo_data;
        cnt <= cnt + CW'(1);
        if (cnt == LAST) keep <= '1;
      end else if (flush_emit) begin
        keep <= keep_mask(cnt);
      end
    end
  end

  assign out_data = lanes;
  assign out_keep = keep;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: FIFO model feeds popped entries into a scoreboard queue;
// an independent monitor unpacks every accepted word and compares lanes in order.
module tb_fifo_word_packer;
  localparam int W = 8;
  localparam int L = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           fifo_empty = 1'b1;
  logic           fifo_rd_en;
  logic [W-1:0]   fifo_data = '0;
  logic           flush = 1'b0;
  logic [W*L-1:0] out_data;
  logic [L-1:0]   out_keep;
  logic           out_valid;
  logic           out_ready = 1'b0;

  fifo_word_packer #(.WIDTH(W), .LANES(L)) dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_data(fifo_data), .flush(flush), .out_data(out_data), .out_keep(out_keep),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] exp_q[$];
  int           pops = 0;
  int           steps = 0;
  int           pop_steps[$];
  bit           stall = 1'b1;
  bit           flush_k = 1'b0;
  bit           ready_k = 1'b0;
  int           words = 0;
  logic [31:0]  last_data = '0;
  logic [3:0]   last_keep = '0;
  int           last_vlen = 0;

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic bit contig(input logic [3:0] k);
    logic [3:0] t;
    t = k + 4'd1;
    return (k != 4'd0) && ((k & t) == 4'd0);
  endfunction

  // One clock of the upstream FIFO: data appears the cycle after the pop cycle.
  task automatic step();
    logic [W-1:0] v;
    bit popped;
    v = '0;
    fifo_empty = (q.size() == 0) || stall;
    flush      = flush_k;
    out_ready  = ready_k;
    #1;
    popped = fifo_rd_en && !fifo_empty;
    chk(!(fifo_rd_en && fifo_empty), "rd_en_while_empty", {31'd0, fifo_rd_en}, 32'd0);
    if (rst) chk(fifo_rd_en == 1'b0, "rd_en_in_reset", {31'd0, fifo_rd_en}, 32'd0);
    if (popped) begin
      v = q.pop_front();
      exp_q.push_back(v);
      pops++;
      pop_steps.push_back(steps);
    end
    @(posedge clk);
    #1;
    steps++;
    if (rst) exp_q.delete();
    fifo_data = popped ? v : W'($urandom);
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic reset_dut();
    rst = 1'b1; stall = 1'b1; flush_k = 1'b0; ready_k = 1'b0;
    step();
    chk(out_valid == 1'b0, "reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk(out_data == '0, "reset_out_data", out_data, 32'd0);
    chk(out_keep == '0, "reset_out_keep", {28'd0, out_keep}, 32'd0);
    chk(fifo_rd_en == 1'b0, "reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    step();
    rst = 1'b0; stall = 1'b0;
    q.delete(); pops = 0; pop_steps.delete();
  endtask

  // Monitor: every accepted word is unpacked lane by lane against the pop order.
  logic [W*L-1:0] prev_data;
  logic [L-1:0]   prev_keep;
  bit             held = 1'b0;
  int             vlen = 0;
  always @(negedge clk) begin
    if (rst) begin
      held = 1'b0; vlen = 0;
    end else if (out_valid) begin
      vlen++;
      if (held) chk((out_data == prev_data) && (out_keep == prev_keep), "hold_stable", out_data, prev_data);
      if (out_ready) begin
        chk(contig(out_keep), "keep_contiguous", {28'd0, out_keep}, 32'hF);
        for (int i = 0; i < L; i++) begin
          if (out_keep[i]) begin
            if (exp_q.size() == 0) chk(1'b0, "extra_lane", {24'd0, out_data[i*W +: W]}, 32'd0);
            else begin
              logic [W-1:0] e;
              e = exp_q.pop_front();
              chk(out_data[i*W +: W] == e, "lane_data", {24'd0, out_data[i*W +: W]}, {24'd0, e});
            end
          end else begin
            chk(out_data[i*W +: W] == '0, "unused_lane_zero", {24'd0, out_data[i*W +: W]}, 32'd0);
          end
        end
        last_data = out_data; last_keep = out_keep; last_vlen = vlen;
        words++; held = 1'b0; vlen = 0;
      end else begin
        held = 1'b1; prev_data = out_data; prev_keep = out_keep;
      end
    end else begin
      held = 1'b0; vlen = 0;
    end
  end

  initial begin
    int w0;
    logic [W-1:0] v[8];
    @(posedge clk); #1;

    // Four entries, downstream always ready.
    reset_dut();
    ready_k = 1'b1;
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    w0 = words;
    run(10);
    chk(pop_steps.size() == 4, "full_pop_count", pop_steps.size(), 32'd4);
    if (pop_steps.size() == 4)
      chk(pop_steps[3] - pop_steps[0] == 3, "pops_consecutive", pop_steps[3] - pop_steps[0], 32'd3);
    chk(words == w0 + 1, "full_word_count", words - w0, 32'd1);
    chk(last_data == 32'h44332211, "full_word_data", last_data, 32'h44332211);
    chk(last_keep == 4'b1111, "full_word_keep", {28'd0, last_keep}, 32'hF);
    chk(last_vlen == 1, "full_valid_len", last_vlen, 32'd1);

    // Two entries then flush.
    reset_dut();
    ready_k = 1'b1;
    q = '{8'hAA, 8'hBB};
    w0 = words;
    run(6);
    flush_k = 1'b1; step(); flush_k = 1'b0;
    run(6);
    chk(words == w0 + 1, "partial_word_count", words - w0, 32'd1);
    chk(last_data == 32'h0000BBAA, "partial_word_data", last_data, 32'h0000BBAA);
    chk(last_keep == 4'b0011, "partial_word_keep", {28'd0, last_keep}, 32'h3);

    // Flush with nothing captured: no word, and popping resumes afterwards.
    reset_dut();
    ready_k = 1'b1;
    w0 = words;
    flush_k = 1'b1; step(); flush_k = 1'b0;
    run(4);
    chk(words == w0, "empty_flush_no_word", words - w0, 32'd0);
    q.push_back(8'h5A);
    run(4);
    chk(pops == 1, "pop_after_empty_flush", pops, 32'd1);
    flush_k = 1'b1; step(); flush_k = 1'b0;
    run(6);
    chk(last_keep == 4'b0001, "single_lane_keep", {28'd0, last_keep}, 32'h1);
    chk(last_data == 32'h0000005A, "single_lane_data", last_data, 32'h5A);

    // Backpressure held for well over 10 cycles in DRAIN.
    reset_dut();
    for (int i = 0; i < 8; i++) begin v[i] = W'($urandom); q.push_back(v[i]); end
    w0 = words;
    run(20);
    chk(pops == 4, "no_pop_while_draining", pops, 32'd4);
    chk(out_valid == 1'b1, "valid_held", {31'd0, out_valid}, 32'd1);
    ready_k = 1'b1;
    step();
    chk(last_vlen >= 10, "valid_len_backpressure", last_vlen, 32'd10);
    chk(last_data == {v[3], v[2], v[1], v[0]}, "bp_word0_data", last_data, {v[3], v[2], v[1], v[0]});
    run(15);
    chk(words == w0 + 2, "bp_word_count", words - w0, 32'd2);
    chk(last_data == {v[7], v[6], v[5], v[4]}, "bp_word1_data", last_data, {v[7], v[6], v[5], v[4]});

    // Reset with two lanes captured and a pop in flight.
    reset_dut();
    ready_k = 1'b1;
    for (int i = 0; i < 8; i++) begin v[i] = W'($urandom); q.push_back(v[i]); end
    w0 = words;
    run(3);
    rst = 1'b1;
    step();
    chk(out_valid == 1'b0, "midfill_reset_valid", {31'd0, out_valid}, 32'd0);
    chk(out_data == '0, "midfill_reset_data", out_data, 32'd0);
    chk(out_keep == '0, "midfill_reset_keep", {28'd0, out_keep}, 32'd0);
    rst = 1'b0;
    run(9);
    chk(words == w0 + 1, "post_reset_word_count", words - w0, 32'd1);
    chk(last_data == {v[6], v[5], v[4], v[3]}, "post_reset_word", last_data, {v[6], v[5], v[4], v[3]});

    // Random traffic: every popped entry must come out exactly once, in order.
    reset_dut();
    for (int i = 0; i < 1000; i++) q.push_back(W'($urandom));
    for (int n = 0; n < 30000 && pops < 1000; n++) begin
      stall   = ($urandom_range(0, 9) < 3);
      ready_k = ($urandom_range(0, 9) < 6);
      flush_k = ($urandom_range(0, 19) == 0);
      step();
    end
    stall = 1'b0; ready_k = 1'b1; flush_k = 1'b0;
    run(6);
    flush_k = 1'b1; step(); flush_k = 1'b0;
    run(12);
    chk(pops == 1000, "random_pop_total", pops, 32'd1000);
    chk(exp_q.size() == 0, "random_all_delivered", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
